hazard_ctrl: RTL and testbench

Issue-stage hazard controller for the pipelined ARM32 core. Tracks destination registers of the instructions in the execute (EX) and memory (MEM) stages, drives the datapath forwarding selects (`sel_A_in`, `sel_B_in`, `sel_shift_in`) and the operand-latch enables (`en_A`, `en_B`, `en_S`), and stalls decode on load-use, link-register and store-data hazards. Sits between the decoder and the datapath; it is the only block that writes those six datapath controls.

---
 rtl/pipeline_pkg.sv | 32 +++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_src_resolve.sv | 46 ++++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the issue-stage hazard controller.
package pipeline_pkg;

    // Operand forwarding select driven into the datapath muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file
        FWD_ALU = 2'b01,   // ALU_out of the instruction in EX
        FWD_LDR = 2'b10,   // w_data_ldr of the load in MEM
        FWD_ALT = 2'b11    // pc_out on A, zero on the shift source
    } fwd_sel_e;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    // Everything the hazard logic needs to remember about the EX instruction.
    typedef struct packed {
        logic       v;
        logic       wr;
        logic [3:0] addr;
        logic       lr;
        logic       ldr;
        logic [3:0] ldr_addr;
    } ex_stage_t;

    // True when the EX instruction will write register r by any port.
    function automatic logic ex_writes(ex_stage_t ex, logic [3:0] r);
        return ex.v & ((ex.wr & (ex.addr == r)) |
                       (ex.lr & (r == REG_LR)) |
                       (ex.ldr & (ex.ldr_addr == r)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-to-hazard-controller bundle: decoded source/destination fields in,
// stall, latch enables and forwarding selects out.
interface hazard_ctrl_if;
    logic       dec_valid;
    logic [3:0] dec_A_addr;
    logic [3:0] dec_B_addr;
    logic [3:0] dec_shift_addr;
    logic [3:0] dec_str_addr;
    logic       dec_use_A;
    logic       dec_use_B;
    logic       dec_use_S;
    logic       dec_use_str;
    logic       dec_wr;
    logic [3:0] dec_w_addr;
    logic       dec_lr;
    logic       dec_ldr;
    logic [3:0] dec_ldr_addr;
    logic       flush;
    logic       stall;
    logic       en_A;
    logic       en_B;
    logic       en_S;
    logic [1:0] sel_A_in;
    logic [1:0] sel_B_in;
    logic [1:0] sel_shift_in;

    // Decoder / control side.
    modport master (
        output dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_str_addr,
               dec_use_A, dec_use_B, dec_use_S, dec_use_str,
               dec_wr, dec_w_addr, dec_lr, dec_ldr, dec_ldr_addr, flush,
        input  stall, en_A, en_B, en_S, sel_A_in, sel_B_in, sel_shift_in
    );

    // Hazard controller side.
    modport slave (
        input  dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_str_addr,
               dec_use_A, dec_use_B, dec_use_S, dec_use_str,
               dec_wr, dec_w_addr, dec_lr, dec_ldr, dec_ldr_addr, flush,
        output stall, en_A, en_B, en_S, sel_A_in, sel_B_in, sel_shift_in
    );
endinterface

// File: rtl/hazard_src_resolve.sv
// Resolves one operand source against the EX/MEM writers: picks the
// forwarding select and raises a stall request when no forward path exists.
module hazard_src_resolve
    import pipeline_pkg::*;
(
    input  logic       i_addr_vld_unused_tie, // kept low; reserved
    input  logic [3:0] i_addr,
    input  logic       i_use,
    input  logic       i_pc_alt,      // r15 reads pc_out (A source only)
    input  logic       i_unused_alt,  // unused source selects zero (S source)
    input  ex_stage_t  i_ex,
    input  logic       i_mem_v,
    input  logic [3:0] i_mem_ldr_addr,
    output fwd_sel_e   o_sel,
    output logic       o_stall_req
);
    logic w_ex_alu_hit;
    logic w_ex_ldr_hit;
    logic w_ex_lr_hit;
    logic w_mem_hit;

    assign w_ex_alu_hit = i_ex.v & i_ex.wr  & (i_ex.addr == i_addr);
    assign w_ex_ldr_hit = i_ex.v & i_ex.ldr & (i_ex.ldr_addr == i_addr);
    assign w_ex_lr_hit  = i_ex.v & i_ex.lr  & (i_addr == REG_LR);
    assign w_mem_hit    = i_mem_v & (i_mem_ldr_addr == i_addr) & ~i_addr_vld_unused_tie;

    // Priority: unused, r15, EX port-1 (younger), EX load (stall), MEM load.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_sel       = FWD_RF;
        o_stall_req = 1'b0;
        if (!i_use) begin
            o_sel = i_unused_alt ? FWD_ALT : FWD_RF;
        end else if (i_addr == REG_PC) begin
            o_sel = i_pc_alt ? FWD_ALT : FWD_RF;
        end else begin
            // LR is written from LR_in, not ALU_out, so it cannot be forwarded.
            o_stall_req = w_ex_ldr_hit | w_ex_lr_hit;
            if (w_ex_alu_hit) begin
                o_sel = FWD_ALU;
            end else if (w_mem_hit && !w_ex_ldr_hit) begin
                o_sel = FWD_LDR;
            end
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Issue-stage hazard controller: tracks EX/MEM writers, drives forwarding
// selects and operand-latch enables, and stalls decode on unforwardable hazards.
module hazard_ctrl
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz
);
    ex_stage_t  r_ex;
    logic       r_mem_v;
    logic [3:0] r_mem_ldr_addr;

    fwd_sel_e   w_sel_a;
    fwd_sel_e   w_sel_b;
    fwd_sel_e   w_sel_s;
    logic       w_req_a;
    logic       w_req_b;
    logic       w_req_s;
    logic       w_req_str;
    logic       w_hazard;
    logic       w_stall;
    logic       w_issue;

    hazard_src_resolve u_src_a (
        .i_addr_vld_unused_tie (1'b0),
        .i_addr                (hz.dec_A_addr),
        .i_use                 (hz.dec_use_A),
        .i_pc_alt              (1'b1),
        .i_unused_alt          (1'b0),
        .i_ex                  (r_ex),
        .i_mem_v               (r_mem_v),
        .i_mem_ldr_addr        (r_mem_ldr_addr),
        .o_sel                 (w_sel_a),
        .o_stall_req           (w_req_a)
    );

    hazard_src_resolve u_src_b (
        .i_addr_vld_unused_tie (1'b0),
        .i_addr                (hz.dec_B_addr),
        .i_use                 (hz.dec_use_B),
        .i_pc_alt              (1'b0),
        .i_unused_alt          (1'b0),
        .i_ex                  (r_ex),
        .i_mem_v               (r_mem_v),
        .i_mem_ldr_addr        (r_mem_ldr_addr),
        .o_sel                 (w_sel_b),
        .o_stall_req           (w_req_b)
    );

    hazard_src_resolve u_src_s (
        .i_addr_vld_unused_tie (1'b0),
        .i_addr                (hz.dec_shift_addr),
        .i_use                 (hz.dec_use_S),
        .i_pc_alt              (1'b0),
        .i_unused_alt          (1'b1),
        .i_ex                  (r_ex),
        .i_mem_v               (r_mem_v),
        .i_mem_ldr_addr        (r_mem_ldr_addr),
        .o_sel                 (w_sel_s),
        .o_stall_req           (w_req_s)
    );

    // Store data has no forward path: wait out every pending writer of it.
    assign w_req_str = hz.dec_use_str &
                       (ex_writes(r_ex, hz.dec_str_addr) |
                        (r_mem_v & (r_mem_ldr_addr == hz.dec_str_addr)));

    assign w_hazard = w_req_a | w_req_b | w_req_s | w_req_str;
    assign w_stall  = hz.dec_valid & ~hz.flush & w_hazard;
    assign w_issue  = hz.dec_valid & ~hz.flush & ~w_hazard;

    assign hz.stall        = w_stall;
    assign hz.en_A         = w_issue;
    assign hz.en_B         = w_issue;
    assign hz.en_S         = w_issue;
    assign hz.sel_A_in     = hz.dec_valid ? w_sel_a : FWD_RF;
    assign hz.sel_B_in     = hz.dec_valid ? w_sel_b : FWD_RF;
    assign hz.sel_shift_in = hz.dec_valid ? w_sel_s
                                          : (hz.dec_use_S ? FWD_RF : FWD_ALT);

    // Advance the EX/MEM tracking; a stall or flush injects a bubble into EX.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every stage samples the pre-edge value of the one before it.
        if (rst) begin
            r_ex           <= '0;
            r_mem_v        <= 1'b0;
            r_mem_ldr_addr <= '0;
        end else begin
            r_mem_v        <= r_ex.v & r_ex.ldr;
            r_mem_ldr_addr <= r_ex.ldr_addr;
            if (w_issue) begin
                r_ex <= '{v:        1'b1,
                          wr:       hz.dec_wr,
                          addr:     hz.dec_w_addr,
                          lr:       hz.dec_lr,
                          ldr:      hz.dec_ldr,
                          ldr_addr: hz.dec_ldr_addr};
            end else begin
                r_ex <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction sequences with
// hand-computed expectations plus a per-cycle comparison against a model
// that tracks pending destination registers as plain integers.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       flush;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic [3:0] str;
        logic       ua;
        logic       ub;
        logic       us;
        logic       ustr;
        logic       wr;
        logic [3:0] w;
        logic       lr;
        logic       ldr;
        logic [3:0] la;
    } dec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- model: pending destinations, -1 = none ----------------
    int m_ex_alu = -1;   // port-1 destination of the EX instruction
    int m_ex_ld  = -1;   // load destination of the EX instruction
    bit m_ex_bl  = 1'b0; // EX instruction writes r14 from LR_in
    int m_mem_ld = -1;   // load destination of the MEM instruction

    function automatic void src_model(input int r, input bit en, input bit is_a,
                                      input bit is_s, output int sel, output bit hzd);
        hzd = 1'b0;
        sel = 0;
        if (!en) begin
            sel = is_s ? 3 : 0;
        end else if (r == 15) begin
            sel = is_a ? 3 : 0;
        end else begin
            hzd = (r == m_ex_ld) || (m_ex_bl && r == 14);
            if (r == m_ex_alu)                     sel = 1;
            else if (r == m_mem_ld && r != m_ex_ld) sel = 2;
        end
    endfunction

    function automatic void model_out(output bit e_stall, output bit e_issue,
                                      output int sa, output int sb, output int ss);
        bit ha, hb, hs, hst, any;
        int sr;
        src_model(int'(hz.dec_A_addr), hz.dec_use_A, 1'b1, 1'b0, sa, ha);
        src_model(int'(hz.dec_B_addr), hz.dec_use_B, 1'b0, 1'b0, sb, hb);
        src_model(int'(hz.dec_shift_addr), hz.dec_use_S, 1'b0, 1'b1, ss, hs);
        sr  = int'(hz.dec_str_addr);
        hst = hz.dec_use_str && (sr == m_ex_alu || sr == m_ex_ld ||
                                 (m_ex_bl && sr == 14) || sr == m_mem_ld);
        any = ha || hb || hs || hst;
        e_stall = hz.dec_valid && !hz.flush && any;
        e_issue = hz.dec_valid && !hz.flush && !any;
        if (!hz.dec_valid) begin
            sa = 0;
            sb = 0;
            ss = hz.dec_use_S ? 0 : 3;
        end
    endfunction

    // Model state update: what each stage holds after the edge.
    always @(posedge clk or posedge rst) begin : model_upd
        bit u_stall, u_issue;
        int u_a, u_b, u_s;
        if (rst) begin
            m_ex_alu <= -1;
            m_ex_ld  <= -1;
            m_ex_bl  <= 1'b0;
            m_mem_ld <= -1;
        end else begin
            model_out(u_stall, u_issue, u_a, u_b, u_s);
            m_mem_ld <= m_ex_ld;
            m_ex_alu <= (u_issue && hz.dec_wr)  ? int'(hz.dec_w_addr)   : -1;
            m_ex_ld  <= (u_issue && hz.dec_ldr) ? int'(hz.dec_ldr_addr) : -1;
            m_ex_bl  <= u_issue && hz.dec_lr;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        bit c_stall, c_issue;
        int c_a, c_b, c_s;
        model_out(c_stall, c_issue, c_a, c_b, c_s);
        check("cyc_stall", int'(hz.stall), int'(c_stall));
        check("cyc_en_A",  int'(hz.en_A),  int'(c_issue));
        check("cyc_en_B",  int'(hz.en_B),  int'(c_issue));
        check("cyc_en_S",  int'(hz.en_S),  int'(c_issue));
        check("cyc_sel_A", int'(hz.sel_A_in), c_a);
        check("cyc_sel_B", int'(hz.sel_B_in), c_b);
        check("cyc_sel_S", int'(hz.sel_shift_in), c_s);
    end

    // ---------------- stimulus helpers ----------------
    function automatic dec_t d_idle();
        dec_t d = '0;
        return d;
    endfunction

    function automatic dec_t d_alu(input logic [3:0] w, input logic [3:0] a, input logic [3:0] b);
        dec_t d = '0;
        d.valid = 1'b1; d.ua = 1'b1; d.a = a; d.ub = 1'b1; d.b = b;
        d.wr = 1'b1; d.w = w;
        return d;
    endfunction

    function automatic dec_t d_mov(input logic [3:0] w, input logic [3:0] a);
        dec_t d = '0;
        d.valid = 1'b1; d.ua = 1'b1; d.a = a; d.wr = 1'b1; d.w = w;
        return d;
    endfunction

    function automatic dec_t d_ldr(input logic [3:0] la, input logic [3:0] a);
        dec_t d = '0;
        d.valid = 1'b1; d.ua = 1'b1; d.a = a; d.ldr = 1'b1; d.la = la;
        return d;
    endfunction

    function automatic dec_t d_bl();
        dec_t d = '0;
        d.valid = 1'b1; d.lr = 1'b1;
        return d;
    endfunction

    function automatic dec_t d_str(input logic [3:0] sr, input logic [3:0] a);
        dec_t d = '0;
        d.valid = 1'b1; d.ua = 1'b1; d.a = a; d.ustr = 1'b1; d.str = sr;
        return d;
    endfunction

    task automatic drive(input dec_t d);
        hz.dec_valid      = d.valid;
        hz.flush          = d.flush;
        hz.dec_A_addr     = d.a;
        hz.dec_B_addr     = d.b;
        hz.dec_shift_addr = d.s;
        hz.dec_str_addr   = d.str;
        hz.dec_use_A      = d.ua;
        hz.dec_use_B      = d.ub;
        hz.dec_use_S      = d.us;
        hz.dec_use_str    = d.ustr;
        hz.dec_wr         = d.wr;
        hz.dec_w_addr     = d.w;
        hz.dec_lr         = d.lr;
        hz.dec_ldr        = d.ldr;
        hz.dec_ldr_addr   = d.la;
    endtask

    // Apply a decode word and move to the sampling point of that cycle.
    task automatic present(input dec_t d);
        drive(d);
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dec_t d;
        rst = 1'b1;
        drive(d_idle());

        // Reset state
        present(d_idle());
        check("rst_stall", int'(hz.stall), 0);
        check("rst_en_A",  int'(hz.en_A), 0);
        check("rst_sel_A", int'(hz.sel_A_in), 0);
        check("rst_sel_S", int'(hz.sel_shift_in), 3);
        next_cycle();
        rst = 1'b0;

        // ADD r1 ; ADD r2,r1,r3 -> forward ALU_out
        present(d_alu(4'd1, 4'd2, 4'd3));
        check("add1_en_A",  int'(hz.en_A), 1);
        check("add1_stall", int'(hz.stall), 0);
        next_cycle();
        present(d_alu(4'd2, 4'd1, 4'd3));
        check("chain_sel_A", int'(hz.sel_A_in), 1);
        check("chain_stall", int'(hz.stall), 0);
        next_cycle();

        // LDR r4 ; SUB r5,r4,#1 -> one stall, then forward w_data_ldr
        present(d_ldr(4'd4, 4'd9));
        check("ldr4_stall", int'(hz.stall), 0);
        next_cycle();
        present(d_mov(4'd5, 4'd4));
        check("lu0_stall", int'(hz.stall), 1);
        check("lu0_en_A",  int'(hz.en_A), 0);
        next_cycle();
        present(d_mov(4'd5, 4'd4));
        check("lu1_stall", int'(hz.stall), 0);
        check("lu1_sel_A", int'(hz.sel_A_in), 2);
        next_cycle();

        // LDR r6 (MEM) and ADD r6 (EX): younger writer wins
        present(d_ldr(4'd6, 4'd9));
        next_cycle();
        present(d_alu(4'd6, 4'd1, 4'd2));
        next_cycle();
        present(d_alu(4'd8, 4'd6, 4'd0));
        check("young_sel_A", int'(hz.sel_A_in), 1);
        check("young_stall", int'(hz.stall), 0);
        next_cycle();

        // BL ; MOV r0,r14 -> one stall, then regfile
        present(d_bl());
        next_cycle();
        present(d_mov(4'd0, 4'd14));
        check("lr0_stall", int'(hz.stall), 1);
        next_cycle();
        present(d_mov(4'd0, 4'd14));
        check("lr1_stall", int'(hz.stall), 0);
        check("lr1_sel_A", int'(hz.sel_A_in), 0);
        next_cycle();

        // ADD r7 ; STR r7 -> one stall until r7 commits
        present(d_alu(4'd7, 4'd1, 4'd2));
        next_cycle();
        present(d_str(4'd7, 4'd9));
        check("st0_stall", int'(hz.stall), 1);
        next_cycle();
        present(d_str(4'd7, 4'd9));
        check("st1_stall", int'(hz.stall), 0);
        check("st1_en_A",  int'(hz.en_A), 1);
        next_cycle();

        // LDR r10 ; STR r10 -> two stalls (EX then MEM)
        present(d_ldr(4'd10, 4'd9));
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            present(d_str(4'd10, 4'd9));
            check("stld_stall", int'(hz.stall), (i < 2) ? 1 : 0);
            next_cycle();
        end

        // A = r15 -> pc_out
        present(d_mov(4'd1, 4'd15));
        check("pc_sel_A", int'(hz.sel_A_in), 3);
        check("pc_stall", int'(hz.stall), 0);
        next_cycle();

        // B and S forwarding, r15 on B is the regfile
        present(d_alu(4'd13, 4'd1, 4'd2));
        next_cycle();
        d = d_alu(4'd3, 4'd15, 4'd13);
        d.us = 1'b1;
        d.s  = 4'd13;
        present(d);
        check("bs_sel_A", int'(hz.sel_A_in), 3);
        check("bs_sel_B", int'(hz.sel_B_in), 1);
        check("bs_sel_S", int'(hz.sel_shift_in), 1);
        next_cycle();
        d = d_alu(4'd3, 4'd1, 4'd15);
        present(d);
        check("b15_sel_B", int'(hz.sel_B_in), 0);
        next_cycle();

        // flush during a load-use stall: no stall, bubble, load still advances
        present(d_ldr(4'd11, 4'd9));
        next_cycle();
        d = d_mov(4'd12, 4'd11);
        d.flush = 1'b1;
        present(d);
        check("fl_stall", int'(hz.stall), 0);
        check("fl_en_A",  int'(hz.en_A), 0);
        next_cycle();
        present(d_mov(4'd12, 4'd11));
        check("fl1_sel_A", int'(hz.sel_A_in), 2);
        check("fl1_stall", int'(hz.stall), 0);
        next_cycle();

        // rst mid-stall: context dropped, re-presented instruction issues
        present(d_ldr(4'd4, 4'd9));
        next_cycle();
        present(d_mov(4'd5, 4'd4));
        check("rs0_stall", int'(hz.stall), 1);
        #1 rst = 1'b1;
        #1 check("rs_async_stall", int'(hz.stall), 0);
        present(d_idle());
        check("rs_stall", int'(hz.stall), 0);
        check("rs_en_A",  int'(hz.en_A), 0);
        check("rs_sel_A", int'(hz.sel_A_in), 0);
        check("rs_sel_B", int'(hz.sel_B_in), 0);
        next_cycle();
        rst = 1'b0;
        present(d_mov(4'd5, 4'd4));
        check("rs1_stall", int'(hz.stall), 0);
        check("rs1_sel_A", int'(hz.sel_A_in), 0);
        next_cycle();

        present(d_idle());
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
